demux1to2_16bit_buf: RTL
========================

# demux1to2_16bit_buf

Buffered 1-to-2 demultiplexer for 16-bit data words with valid/ready handshakes on every port. Each accepted input beat is steered by its `sel` bit into one of two independent 2-entry FIFOs, and each FIFO drains to its own output channel. The block performs the inverse of the 2-to-1 16-bit select path: it distributes one producer's data to two consumers inside the CPU datapath. Per-channel 16-bit beat counters support debug and verification.

## Interface
Parameters:
- `WIDTH`, 16, data word width; all data ports and FIFO entries use this width.
- `DEPTH`, 2, entries per output FIFO; fixed at 2, pointers are 1 bit.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  1  destination select: 0 routes to channel 0, 1 routes to channel 1.
- `in_valid`  in  1  producer has a beat.
- `in_ready`  out  1  block accepts the beat this cycle.
- `out0_data`, `out1_data`  out  WIDTH  head word of each channel FIFO.
- `out0_valid`, `out1_valid`  out  1  channel FIFO is non-empty.
- `out0_ready`, `out1_ready`  in  1  consumer takes the head word.
- `cnt0`, `cnt1`  out  16  beats accepted per channel, wrapping.

## Operation
- Accept: a beat is accepted when `in_valid & in_ready` at a rising edge. It is written to the tail of FIFO[`in_sel`], and that FIFO's count increments.
- `in_ready` is combinational and equals `rst_n & (count[in_sel] < 2)`.
  - It depends only on the selected FIFO, so a full channel 1 does not block beats destined for channel 0.
  - There is no full-FIFO pass-through: a pop in the same cycle does not raise `in_ready` when the selected FIFO is full.
- Pop: channel k pops when `outk_valid & outk_ready`. Its read pointer advances and its count decrements.
- Simultaneous push and pop on the same channel: count is unchanged and both pointers advance.
- The two channels operate fully independently. Both may pop in the same cycle as a push to either channel.
- Ordering: each channel delivers its beats in acceptance order. There is no ordering relation between channels.
- `outk_valid` = (count[k] != 0).
- `outk_data` = the head entry when valid, otherwise 16'h0000.
- Each FIFO has a 1-bit write pointer, a 1-bit read pointer and a 2-bit count (0..2). Pointers wrap 1 to 0.
- Counters: `cntk` increments by 1 on every beat accepted into channel k and wraps from 16'hFFFF to 16'h0000. It never counts pops.
- Input stability (`in_data` and `in_sel` held while `in_valid` is high and `in_ready` is low) is not required. `in_sel` is re-evaluated every cycle.
- Reset (`rst_n` low at a rising edge):
  - All counts, pointers, `cnt0` and `cnt1` clear to 0.
  - FIFO storage clears to 0.
  - Outputs after reset: `out0_valid` = `out1_valid` = 0, `out0_data` = `out1_data` = 0, and `in_ready` = 0 while `rst_n` is low.
  - Reset mid-operation discards all buffered beats with no further output.
  - Handshakes presented in the reset cycle are ignored.

## Timing
- Latency: a beat accepted at edge N appears on `outk_valid`/`outk_data` after edge N (registered; no combinational input-to-output path).
- Throughput: 1 beat/cycle sustained per channel when its consumer holds ready high.
- Combinational paths: `in_sel` → `in_ready`, and `rst_n` → `in_ready`. There is no ready-to-ready path between input and outputs.
- Boundaries:
  - Empty channel with push: valid the next cycle.
  - Full channel with pop only: count becomes 1 and `in_ready` rises the next cycle for that `in_sel`.
  - Empty channel with `outk_ready` high: no effect.

## Test plan
- Reset/idle: hold `rst_n`=0 for 2 cycles with `in_valid`=1 → `in_ready`=0, both valids 0, both data outputs 0, `cnt0`=`cnt1`=0. Release reset → `in_ready`=1.
- Routing and latency: push 16'hA5A5 with sel=0, then 16'h5A5A with sel=1, both consumers ready → `out0_data`=A5A5 one cycle after the first accept, `out1_data`=5A5A one cycle after the second, `cnt0`=1, `cnt1`=1.
- Full/backpressure: `out0_ready`=0; push 0x0001, 0x0002, 0x0003 to channel 0 → the third is stalled (`in_ready`=0). Push 0x0004 with sel=1 → accepted. Raise `out0_ready` → channel 0 delivers 0x0001, 0x0002, 0x0003 in order and `cnt0`=3.
- Simultaneous push/pop: channel 0 holds 1 entry, then push and pop in the same cycle for 20 cycles with incrementing data → count stays 1, no data loss, and output order equals input order.
- Counter wrap: force 65536 beats to channel 1 → `cnt1` reads 0 and `cnt0` is unchanged.
- Reset mid-operation: both FIFOs full, assert `rst_n`=0 for 1 cycle → valids 0, counters 0. A fresh push after release is delivered and no stale data appears.

Source files
------------

// File: rtl/demux1to2_16bit_buf_if.sv
// Bundle of the producer-side and both consumer-side valid/ready channels of the
// buffered 1-to-2 demux, plus the per-channel accepted-beat counters.
interface demux1to2_16bit_buf_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [15:0]      cnt0;
  logic [15:0]      cnt1;

  // Drives the input beat and consumes both output channels.
  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  // The demux itself.
  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux1to2_16bit_buf.sv
// Buffered 1-to-2 demux: each accepted beat goes to the 2-entry FIFO picked by
// in_sel; each FIFO drains independently to its own output channel.
module demux1to2_16bit_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  demux1to2_16bit_buf_if.slave     bus
);
  // Handshake: a transfer happens on any port at a rising edge where valid and
  // ready are both high; valid never depends on ready of the same port.

  logic [WIDTH-1:0] mem_q   [2][2];
  logic             wr_q    [2];
  logic             rd_q    [2];
  logic [1:0]       count_q [2];
  logic [1:0]       count_d [2];
  logic [15:0]      cnt_q   [2];
  logic             push    [2];
  logic             pop     [2];
  logic             valid   [2];
  logic             ready   [2];
  logic [WIDTH-1:0] head    [2];

  // Ready looks only at the selected FIFO; no same-cycle pop pass-through.
  assign bus.in_ready = rst_n & (count_q[bus.in_sel] < 2'(DEPTH));

  assign ready[0] = bus.out0_ready;
  assign ready[1] = bus.out1_ready;

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      valid[k]   = (count_q[k] != 2'd0);
      head[k]    = valid[k] ? mem_q[k][rd_q[k]] : '0;
      push[k]    = bus.in_valid & bus.in_ready & (bus.in_sel == k[0]);
      pop[k]     = valid[k] & ready[k];
      count_d[k] = count_q[k] + {1'b0, push[k]} - {1'b0, pop[k]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        mem_q[k][0] <= '0;
        mem_q[k][1] <= '0;
        wr_q[k]     <= 1'b0;
        rd_q[k]     <= 1'b0;
        count_q[k]  <= 2'd0;
        cnt_q[k]    <= 16'h0000;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (push[k]) begin
          mem_q[k][wr_q[k]] <= bus.in_data;
          wr_q[k]           <= ~wr_q[k];
          cnt_q[k]          <= cnt_q[k] + 16'd1;
        end
        if (pop[k]) rd_q[k] <= ~rd_q[k];
        count_q[k] <= count_d[k];
      end
    end
  end

  assign bus.out0_valid = valid[0];
  assign bus.out0_data  = head[0];
  assign bus.out1_valid = valid[1];
  assign bus.out1_data  = head[1];
  assign bus.cnt0       = cnt_q[0];
  assign bus.cnt1       = cnt_q[1];
endmodule
